clken_gen: RTL and testbench
============================

# clken_gen

Multi-channel, runtime-programmable clock-enable generator; parametrised successor to the fixed 25:1 CPU enable divider. Each channel produces a one-`clk`-wide `clk_enable` pulse every R system clocks. R is reprogrammable without glitches, and each channel supports halt and single-step for CPU debug. Sits in the system block and feeds the 6502 core (channel 0) and slower peripherals (other channels), all in the single `clk` domain.

## Interface
Parameters:
- `CHANNELS`, default 2: number of independent enable channels (≥1).
- `CNT_W`, default 16: counter and divisor width.
- `DEFAULT_DIV`, default 25: divisor loaded into every channel at reset (25 MHz → 1 MHz).

Ports:
- `clk`, in, 1: system clock (25 MHz).
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_we`, in, 1: divisor write strobe, one cycle.
- `cfg_chan`, in, max(1,$clog2(CHANNELS)): target channel of the write.
- `cfg_div`, in, CNT_W: new divisor.
- `ctl_halt`, in, CHANNELS: per-channel halt request, level.
- `ctl_step`, in, CHANNELS: per-channel single-step request, one-cycle pulse.
- `clk_enable`, out, CHANNELS: registered enable pulses.
- `halted`, out, CHANNELS: channel is in the HALTED state.

## Operation
- Per-channel state:
  - `cnt` (CNT_W)
  - `div_active`
  - `div_pending`
  - `pend_valid`
  - state RUN or HALTED
- Effective ratio: R = `div_active`, with 0 treated as 1. R=1 gives `clk_enable` high every cycle while running.
- RUN state:
  - If `cnt` == R−1 (terminal), then `cnt` ← 0.
    - If `ctl_halt` is 0: `clk_enable` ← 1.
    - If `ctl_halt` is 1: the terminal pulse is suppressed, `clk_enable` ← 0, and the state goes to HALTED.
  - Otherwise `cnt` ← `cnt`+1 and `clk_enable` ← 0.
- HALTED state:
  - `cnt` is held at 0 and `halted` = 1.
  - `clk_enable` ← `ctl_step` of that channel, so each step pulse gives exactly one enable pulse.
  - If `ctl_halt` is 0, the state goes to RUN, `clk_enable` ← 0 and `cnt` stays 0. A `ctl_step` in the same cycle is ignored.
- `ctl_step` in RUN is ignored. A halt only takes effect at a terminal count, so running channels always stop on a period boundary.
- Divisor writes:
  - When `cfg_we` is 1 and `cfg_chan` < CHANNELS: `div_pending` ← `cfg_div` and `pend_valid` ← 1. A second write before it is applied overwrites the first.
  - An out-of-range `cfg_chan` is ignored.
- Applying a pending divisor: `div_active` ← `div_pending` and `pend_valid` ← 0. This happens at the channel's next terminal count in RUN, or on the next cycle if the channel is HALTED. A period already in progress therefore always completes with the old R.
- A write and an apply in the same cycle: the apply uses the old `div_pending`, and the new write stays pending (`pend_valid` remains 1).
- Channels are fully independent. There is no phase relationship after different R values are programmed.

## Timing
- Reset values:
  - `cnt` = 0
  - `div_active` = DEFAULT_DIV
  - `pend_valid` = 0
  - state RUN
  - `clk_enable` = all 0
  - `halted` = all 0
- Reset overrides every other input, including mid-period and while HALTED.
- First pulse: `clk_enable` is high in the cycle after the R-th rising edge following `rst` deassertion. After that it repeats every R cycles, one cycle wide.
- Halt: `halted` rises in the cycle after the terminal edge at which `ctl_halt` was sampled high.
- Step: latency is 1 cycle from `ctl_step` to `clk_enable`.
- Release from HALTED: the first pulse comes R cycles after the exit cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset and default rate:** after reset release, channel 0 pulses at cycles 25, 50, 75. Over 250 cycles there are exactly 10 pulses, each one cycle wide.
- **Divisor change mid-period:** with R=25, write `cfg_div`=4 to channel 1 at cnt=10. The current period still ends at 25 cycles, then pulses come every 4 cycles. Also check `cfg_div`=0 and 1, which must give an enable every cycle.
- **Halt and step:** hold `ctl_halt[0]`=1 from cnt=3. The next terminal pulse is suppressed and `halted[0]`=1. Three `ctl_step` pulses give exactly three enables, each 1 cycle later. Release `ctl_halt`; the first pulse arrives 25 cycles later.
- **Simultaneous events:**
  - A release and a step in the same cycle produce no step pulse.
  - A write in the same cycle as a terminal count stays pending to the next boundary.
  - A write to `cfg_chan`=CHANNELS is ignored.
- **Mid-operation reset:** assert `rst` while HALTED with a pending write. Afterwards R=25, `halted`=0 and `pend_valid` is cleared (the first pulse comes at cycle 25).
- **Channel independence:** set channel 0 to R=25 and channel 1 to R=7 and run 175 cycles. Expect 7 and 25 pulses respectively, and halting channel 1 must not perturb channel 0.

Source files
------------

// File: rtl/clken_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clken_gen
//  Purpose  : Multi-channel programmable clock-enable generator with
//             glitch-free divisor updates and per-channel halt / single-step.
//  Revision : 1.0 - initial release
// ============================================================================
module clken_gen #(
    parameter int  CHANNELS    = 2,
    parameter int  CNT_W       = 16,
    parameter int  DEFAULT_DIV = 25,
    localparam int c_CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [c_CHAN_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CHANNELS-1:0] ctl_halt,
    input  logic [CHANNELS-1:0] ctl_step,
    output logic [CHANNELS-1:0] clk_enable,
    output logic [CHANNELS-1:0] halted
);

    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEFAULT = CNT_W'(DEFAULT_DIV);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div_active;
        logic [CNT_W-1:0] r_div_pending;
        logic             r_pend_valid;
        logic             r_enable;
        state_t           r_state;

        logic [CNT_W-1:0] w_last;
        logic             w_terminal;
        logic             w_write;
        logic             w_apply;

        // A divisor of zero behaves like one: terminal on every count.
        assign w_last     = (r_div_active == '0) ? '0 : (r_div_active - c_ONE);
        assign w_terminal = (r_cnt == w_last);
        assign w_write    = cfg_we && (cfg_chan == c_CHAN_W'(gi));
        // New divisors only take effect on a period boundary or while stopped.
        assign w_apply    = r_pend_valid && ((r_state == ST_HALTED) || w_terminal);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt         <= '0;
                r_div_active  <= c_DEFAULT;
                r_div_pending <= c_DEFAULT;
                r_pend_valid  <= 1'b0;
                r_enable      <= 1'b0;
                r_state       <= ST_RUN;
            end else begin
                if (w_apply) begin
                    r_div_active <= r_div_pending;
                end
                if (w_write) begin
                    r_div_pending <= cfg_div;
                    r_pend_valid  <= 1'b1;
                end else if (w_apply) begin
                    r_pend_valid  <= 1'b0;
                end

                case (r_state)
                    ST_RUN: begin
                        if (w_terminal) begin
                            r_cnt <= '0;
                            if (ctl_halt[gi]) begin
                                r_enable <= 1'b0;
                                r_state  <= ST_HALTED;
                            end else begin
                                r_enable <= 1'b1;
                            end
                        end else begin
                            r_cnt    <= r_cnt + c_ONE;
                            r_enable <= 1'b0;
                        end
                    end
                    ST_HALTED: begin
                        r_cnt <= '0;
                        if (ctl_halt[gi]) begin
                            r_enable <= ctl_step[gi];
                        end else begin
                            r_enable <= 1'b0;
                            r_state  <= ST_RUN;
                        end
                    end
                endcase
            end
        end

        assign clk_enable[gi] = r_enable;
        assign halted[gi]     = (r_state == ST_HALTED);
    end

endmodule
`default_nettype wire

// File: tb/tb_clken_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clken_gen
//  Purpose  : Scoreboard bench for clken_gen against a timestamp-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clken_gen;

    localparam int CHANNELS    = 3;
    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 25;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_we;
    logic [1:0]          cfg_chan;
    logic [CNT_W-1:0]    cfg_div;
    logic [CHANNELS-1:0] ctl_halt;
    logic [CHANNELS-1:0] ctl_step;
    logic [CHANNELS-1:0] clk_enable;
    logic [CHANNELS-1:0] halted;

    always #5 clk = ~clk;

    clken_gen #(
        .CHANNELS    (CHANNELS),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_chan   (cfg_chan),
        .cfg_div    (cfg_div),
        .ctl_halt   (ctl_halt),
        .ctl_step   (ctl_step),
        .clk_enable (clk_enable),
        .halted     (halted)
    );

    int checks = 0;
    int errors = 0;
    logic [2*CHANNELS-1:0] exp_q[$];

    // Model: each running channel remembers the edge at which its period began;
    // it is terminal exactly R edges later.
    int m_edge = 0;
    int m_div   [CHANNELS];
    int m_pend  [CHANNELS];
    bit m_pv    [CHANNELS];
    bit m_hlt   [CHANNELS];
    int m_start [CHANNELS];
    int seen    [CHANNELS];

    task automatic model_edge(output logic [2*CHANNELS-1:0] o);
        logic [CHANNELS-1:0] en;
        logic [CHANNELS-1:0] hl;
        en = '0;
        hl = '0;
        m_edge++;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                m_div[c]   = DEFAULT_DIV;
                m_pv[c]    = 1'b0;
                m_hlt[c]   = 1'b0;
                m_start[c] = m_edge;
            end else begin
                int r;
                bit apply;
                r     = (m_div[c] == 0) ? 1 : m_div[c];
                apply = 1'b0;
                if (!m_hlt[c]) begin
                    if (m_edge - m_start[c] == r) begin
                        m_start[c] = m_edge;
                        apply      = m_pv[c];
                        if (ctl_halt[c]) m_hlt[c] = 1'b1;
                        else             en[c]    = 1'b1;
                    end
                end else begin
                    apply = m_pv[c];
                    if (ctl_halt[c]) begin
                        en[c] = ctl_step[c];
                    end else begin
                        m_hlt[c]   = 1'b0;
                        m_start[c] = m_edge;
                    end
                end
                if (apply) begin
                    m_div[c] = m_pend[c];
                    m_pv[c]  = 1'b0;
                end
                if (cfg_we && int'(cfg_chan) == c) begin
                    m_pend[c] = int'(cfg_div);
                    m_pv[c]   = 1'b1;
                end
            end
            hl[c] = m_hlt[c];
        end
        o = {hl, en};
    endtask

    task automatic tick();
        logic [2*CHANNELS-1:0] e;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        for (int c = 0; c < CHANNELS; c++) seen[c] += int'(clk_enable[c]);
        ctl_step = '0;
        cfg_we   = 1'b0;
    endtask

    task automatic clear_seen();
        for (int c = 0; c < CHANNELS; c++) seen[c] = 0;
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic write_div(input int ch, input int div);
        cfg_we   = 1'b1;
        cfg_chan = 2'(ch);
        cfg_div  = CNT_W'(div);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: one registered output word per clock, compared to the queue head.
    initial begin
        logic [2*CHANNELS-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({halted, clk_enable} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got halted=%b en=%b expected halted=%b en=%b",
                             $time, halted, clk_enable, e[2*CHANNELS-1:CHANNELS], e[CHANNELS-1:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int ch;
        rst = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_div = '0;
        ctl_halt = '0; ctl_step = '0;
        clear_seen();

        // Reset state and default rate
        repeat (3) tick();
        check_eq("reset_enable", 32'(clk_enable), 0);
        check_eq("reset_halted", 32'(halted), 0);
        rst = 1'b0;
        clear_seen();
        repeat (250) tick();
        check_eq("default_rate_ch0_pulses", seen[0], 10);

        // Independence: ch1 picks up R=7 at its first boundary
        do_reset();
        write_div(1, 7);
        tick();
        repeat (24) tick();
        clear_seen();
        repeat (175) tick();
        check_eq("indep_ch0_pulses", seen[0], 7);
        check_eq("indep_ch1_pulses", seen[1], 25);

        // Divisor change mid-period, plus 0 and 1 divisors
        do_reset();
        repeat (10) tick();
        write_div(1, 4);
        tick();
        write_div(2, 0);
        clear_seen();
        repeat (13) tick();
        check_eq("midperiod_old_period_held", seen[1], 0);
        tick();
        check_eq("midperiod_boundary_pulse", seen[1], 1);
        clear_seen();
        repeat (40) tick();
        check_eq("new_div4_pulses", seen[1], 10);
        check_eq("div0_every_cycle", seen[2], 40);
        write_div(2, 1);
        tick();
        clear_seen();
        repeat (20) tick();
        check_eq("div1_every_cycle", seen[2], 20);

        // Out-of-range write and write coinciding with a terminal count
        do_reset();
        write_div(CHANNELS, 2);
        tick();
        clear_seen();
        repeat (23) tick();
        write_div(0, 5);
        tick();
        repeat (25) tick();
        check_eq("write_at_terminal_pending", seen[0], 2);
        check_eq("out_of_range_ignored", seen[1], 2);
        clear_seen();
        repeat (25) tick();
        check_eq("write_at_terminal_applied", seen[0], 5);

        // Halt, step, release
        do_reset();
        repeat (3) tick();
        ctl_halt[0] = 1'b1;
        clear_seen();
        repeat (22) tick();
        check_eq("halt_pulse_suppressed", seen[0], 0);
        check_eq("halt_flag_set", 32'(halted[0]), 1);
        clear_seen();
        for (int k = 0; k < 3; k++) begin
            repeat (2) tick();
            ctl_step[0] = 1'b1;
            tick();
        end
        repeat (2) tick();
        check_eq("three_steps", seen[0], 3);
        ctl_halt[0] = 1'b0;
        ctl_step[0] = 1'b1;
        clear_seen();
        tick();
        repeat (24) tick();
        check_eq("release_step_ignored", seen[0], 0);
        tick();
        check_eq("release_first_pulse", seen[0], 1);

        // Reset while halted with a write pending
        ctl_halt[0] = 1'b1;
        repeat (30) tick();
        write_div(0, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctl_halt = '0;
        check_eq("reset_clears_halt", 32'(halted), 0);
        clear_seen();
        repeat (24) tick();
        check_eq("reset_no_early_pulse", seen[0], 0);
        tick();
        check_eq("reset_first_pulse_25", seen[0], 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                ch = $urandom_range(0, CHANNELS - 1);
                ctl_halt[ch] = ~ctl_halt[ch];
            end
            ctl_step = 3'($urandom) & 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                write_div($urandom_range(0, 3), $urandom_range(0, 9));
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        ctl_halt = '0;
        repeat (3) tick();
        @(posedge clk);
        #2;
        check_eq("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
